// File: rtl/score_display_pkg.sv
// score_display_pkg: shared types, segment patterns and slot indices for the score display
package score_display_pkg;
  typedef logic [1:0] digit_idx_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [0:9][6:0] SEG_DIGIT = {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam digit_idx_t IDX_R_ONES = 2'd0;
  localparam digit_idx_t IDX_R_TENS = 2'd1;
  localparam digit_idx_t IDX_L_ONES = 2'd2;
  localparam digit_idx_t IDX_L_TENS = 2'd3;
endpackage

// File: rtl/score_seg7_display_if.sv
// score_seg7_display_if: score digits in, multiplexed seven-segment drive out
// master drives left/right tens/ones (BCD) and receives an/seg/dp (active-low); slave is the display
interface score_seg7_display_if;
  logic [3:0] left_tens;
  logic [3:0] left_ones;
  logic [3:0] right_tens;
  logic [3:0] right_ones;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp;
  modport master (output left_tens, left_ones, right_tens, right_ones, input an, seg, dp);
  modport slave (input left_tens, left_ones, right_tens, right_ones, output an, seg, dp);
endinterface

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD to active-low {g,f,e,d,c,b,a}; invalid codes show a dash
// ports: bcd (4) in, seg (7) out
module bcd_to_seg7
  import score_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb seg = (bcd < 4'd10) ? SEG_DIGIT[bcd] : SEG_DASH;
endmodule

// File: rtl/score_seg7_display.sv
// score_seg7_display: 4-digit multiplexed common-anode display of both players' BCD scores
// ports: clk, reset_n (async active-low), bus (slave: digits in, an/seg/dp out, all active-low)
// option: LEADING_ZERO_BLANK_EN blanks a tens digit whose snapshot value is 0
module score_seg7_display
  import score_display_pkg::*;
#(
  parameter int REFRESH_DIV = 62500,
  parameter int BLANK_CYCLES = 16
) (
  input logic clk,
  input logic reset_n,
  score_seg7_display_if.slave bus
);
  localparam int PW = $clog2(REFRESH_DIV);
  logic [PW-1:0] prescaler;
  digit_idx_t digit_idx;
  logic [3:0] shadow [4];
  logic load_pending;
  logic tick, blank, load;
  logic [3:0] cur;
  logic [6:0] dec, seg_nxt;
  logic [3:0] an_q;
  logic [6:0] seg_q;
  logic dp_q;
  bcd_to_seg7 u_dec (.bcd(cur), .seg(dec));
  always_comb begin
    tick = prescaler == PW'(REFRESH_DIV - 1);
    blank = prescaler < PW'(BLANK_CYCLES);
    // snapshots happen only at a frame boundary (or right after reset) so a frame never mixes scores
    load = load_pending | (tick & (digit_idx == IDX_L_TENS));
    cur = shadow[digit_idx];
`ifdef LEADING_ZERO_BLANK_EN
    seg_nxt = ((digit_idx == IDX_R_TENS || digit_idx == IDX_L_TENS) && cur == 4'd0) ? SEG_BLANK : dec;
`else
    seg_nxt = dec;
`endif
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
      digit_idx <= '0;
      shadow <= '{default: 4'd0};
      load_pending <= 1'b1;
      an_q <= 4'hF;
      seg_q <= SEG_BLANK;
      dp_q <= 1'b1;
    end else begin
      prescaler <= tick ? '0 : prescaler + PW'(1);
      if (tick) digit_idx <= digit_idx + 2'd1;
      if (load) begin
        shadow[IDX_R_ONES] <= bus.right_ones;
        shadow[IDX_R_TENS] <= bus.right_tens;
        shadow[IDX_L_ONES] <= bus.left_ones;
        shadow[IDX_L_TENS] <= bus.left_tens;
        load_pending <= 1'b0;
      end
      an_q <= blank ? 4'hF : ~(4'b1 << digit_idx);
      seg_q <= blank ? SEG_BLANK : seg_nxt;
      dp_q <= blank | (digit_idx != IDX_L_ONES);
    end
  end
  assign bus.an = an_q;
  assign bus.seg = seg_q;
  assign bus.dp = dp_q;
endmodule

// File: tb/tb_score_seg7_display.sv
// tb_score_seg7_display: randomized check of the score display against a cycle-count reference model
module tb_score_seg7_display;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FR = 4 * RD;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int errors = 0;
  int checks = 0;
  score_seg7_display_if bus ();
  score_seg7_display #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;

  // reference: state is just the number of clocks since reset release
  int t = 0;
  int mp, md;
  logic [3:0] snap [4] = '{default: 4'd0};
  logic [3:0] e_an = 4'hF;
  logic [6:0] e_seg = 7'h7F;
  logic e_dp = 1'b1;
  localparam logic [3:0] AN_OF [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  function automatic logic [6:0] ref_seg(input logic [3:0] v, input int slot);
`ifdef LEADING_ZERO_BLANK_EN
    if ((slot == 1 || slot == 3) && v == 4'd0) return 7'h7F;
`endif
    case (v)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t = 0;
      snap = '{default: 4'd0};
      e_an = 4'hF;
      e_seg = 7'h7F;
      e_dp = 1'b1;
    end else begin
      mp = t % RD;
      md = (t / RD) % 4;
      if (mp < BC) begin
        e_an = 4'hF;
        e_seg = 7'h7F;
        e_dp = 1'b1;
      end else begin
        e_an = AN_OF[md];
        e_seg = ref_seg(snap[md], md);
        e_dp = (md == 2) ? 1'b0 : 1'b1;
      end
      if (t == 0 || t % FR == FR - 1)
        snap = '{bus.right_ones, bus.right_tens, bus.left_ones, bus.left_tens};
      t++;
    end
  end

  always @(negedge clk) begin
    chk("model_an", 32'(bus.an), 32'(e_an));
    chk("model_seg", 32'(bus.seg), 32'(e_seg));
    chk("model_dp", 32'(bus.dp), 32'(e_dp));
  end

  task automatic rand_phase(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: bus.left_tens = 4'($urandom_range(0, 15));
          1: bus.left_ones = 4'($urandom_range(0, 15));
          2: bus.right_tens = 4'($urandom_range(0, 15));
          default: bus.right_ones = 4'($urandom_range(0, 15));
        endcase
      end
    end
  endtask

  initial begin
    bus.left_tens = 4'd1;
    bus.left_ones = 4'd2;
    bus.right_tens = 4'd0;
    bus.right_ones = 4'd7;
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(bus.an), 32'h F);
    chk("rst_seg", 32'(bus.seg), 32'h7F);
    chk("rst_dp", 32'(bus.dp), 32'h1);
    reset_n = 1'b1;
    for (int n = 1; n <= 70; n++) begin
      @(negedge clk);
      if (n == 2) chk("blank2_an", 32'(bus.an), 32'hF);
      if (n == 3) chk("idx0_first_an", 32'(bus.an), 32'hE);
      if (n == 4) chk("idx0_seg", 32'(bus.seg), 32'h78);
      if (n == 12) begin
        chk("idx1_an", 32'(bus.an), 32'hD);
        chk("idx1_seg", 32'(bus.seg), 32'(LZ));
      end
      if (n == 20) begin
        chk("idx2_an", 32'(bus.an), 32'hB);
        chk("idx2_seg", 32'(bus.seg), 32'h24);
        chk("idx2_dp", 32'(bus.dp), 32'h0);
      end
      if (n == 28) begin
        chk("idx3_an", 32'(bus.an), 32'h7);
        chk("idx3_seg", 32'(bus.seg), 32'h79);
      end
      if (n == 36) chk("frame1_idx0_seg", 32'(bus.seg), 32'h78);
      if (n == 44) bus.right_ones = 4'd3;
      if (n == 68) chk("frame2_idx0_seg", 32'(bus.seg), 32'h30);
    end
    bus.right_ones = 4'hA;
    bus.left_tens = 4'hF;
    rand_phase(3000);
    for (int k = 0; k < 200 && !(t % FR >= 19 && t % FR <= 22); k++) @(negedge clk);
    @(posedge clk);
    #1 chk("pre_rst_an", 32'(bus.an), 32'hB);
    #1 reset_n = 1'b0;
    #1 begin
      chk("async_an", 32'(bus.an), 32'hF);
      chk("async_seg", 32'(bus.seg), 32'h7F);
      chk("async_dp", 32'(bus.dp), 32'h1);
    end
    bus.left_tens = 4'd0;
    bus.left_ones = 4'd5;
    bus.right_tens = 4'd0;
    bus.right_ones = 4'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int n = 1; n <= 28; n++) begin
      @(negedge clk);
      if (n == 4) begin
        chk("zero_ones_an", 32'(bus.an), 32'hE);
        chk("zero_ones_seg", 32'(bus.seg), 32'h40);
      end
      if (n == 12) chk("zero_rtens_seg", 32'(bus.seg), 32'(LZ));
      if (n == 28) begin
        chk("zero_ltens_an", 32'(bus.an), 32'h7);
        chk("zero_ltens_seg", 32'(bus.seg), 32'(LZ));
      end
    end
    rand_phase(1500);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
